// File: rtl/packet_source_arbiter.sv
// Packet-granular round-robin arbiter: one source owns the output from SOP to EOP.
// Output beat appears 1 cycle after acceptance; oReady of the owner follows the output register's free state.
module packet_source_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int BE_W    = DATA_W / 8,
  parameter int CNT_W   = 16
) (
  input  logic                        iClk,
  input  logic                        iReset,
  input  logic [NUM_SRC-1:0]          iValid,
  input  logic [NUM_SRC*DATA_W-1:0]   iPacket,
  input  logic [NUM_SRC-1:0]          iSop,
  input  logic [NUM_SRC-1:0]          iEop,
  input  logic [NUM_SRC*BE_W-1:0]     iByte_enable,
  output logic [NUM_SRC-1:0]          oReady,
  input  logic                        iReady,
  output logic                        oValid,
  output logic [DATA_W-1:0]           oPacket,
  output logic                        oSop,
  output logic                        oEop,
  output logic [BE_W-1:0]             oByte_enable,
  output logic [$clog2(NUM_SRC)-1:0]  oSrc_id,
  output logic [CNT_W-1:0]            oPkt_count,
  output logic [CNT_W-1:0]            oDrop_count
);

  localparam int SRC_W = $clog2(NUM_SRC);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e              state_q;
  logic [SRC_W-1:0]    ptr_q;
  logic [SRC_W-1:0]    grant_q;
  logic [SRC_W-1:0]    src_id_q;
  logic                valid_q;
  logic                sop_q;
  logic                eop_q;
  logic [DATA_W-1:0]   data_q;
  logic [BE_W-1:0]     be_q;
  logic [CNT_W-1:0]    pkt_cnt_q;
  logic [CNT_W-1:0]    drop_cnt_q;

  logic [NUM_SRC-1:0]  req;
  logic [NUM_SRC-1:0]  junk;
  logic [NUM_SRC-1:0]  rdy_vec;
  logic                out_free;
  logic                accept;
  logic                win_vld;
  logic [SRC_W-1:0]    win_idx;
  logic [SRC_W-1:0]    ptr_next;
  int unsigned         idx;

  logic [DATA_W-1:0]   sel_dat;
  logic [BE_W-1:0]     sel_be;
  logic                sel_sop;
  logic                sel_eop;

  assign req      = iValid & iSop;
  assign junk     = iValid & ~iSop;
  assign out_free = !valid_q || iReady;

  // Scan from the highest offset down so the lowest offset from the pointer wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      if (req[idx]) begin
        win_vld = 1'b1;
        win_idx = SRC_W'(idx);
      end
    end
  end

  // Stray non-SOP beats seen while idle are absorbed so they cannot wedge a source.
  always_comb begin
    rdy_vec = '0;
    if (!iReset) begin
      if (state_q == IDLE) begin
        rdy_vec = junk;
      end else begin
        rdy_vec[grant_q] = out_free;
      end
    end
  end

  assign sel_dat  = iPacket[grant_q*DATA_W +: DATA_W];
  assign sel_be   = iByte_enable[grant_q*BE_W +: BE_W];
  assign sel_sop  = iSop[grant_q];
  assign sel_eop  = iEop[grant_q];
  assign accept   = (state_q == XFER) && iValid[grant_q] && out_free;
  assign ptr_next = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + SRC_W'(1);

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      src_id_q   <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      data_q     <= '0;
      be_q       <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            grant_q <= win_idx;
            state_q <= XFER;
            // Keep the tag of a stalled previous beat until it drains.
            if (out_free) begin
              src_id_q <= win_idx;
            end
          end
          if (|junk) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
          end
        end
        XFER: begin
          if (accept && sel_eop) begin
            state_q <= IDLE;
            ptr_q   <= ptr_next;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        valid_q  <= 1'b1;
        data_q   <= sel_dat;
        be_q     <= sel_be;
        sop_q    <= sel_sop;
        eop_q    <= sel_eop;
        src_id_q <= grant_q;
      end else if (iReady) begin
        valid_q <= 1'b0;
      end

      if (valid_q && iReady && eop_q) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      end
    end
  end

  assign oReady       = rdy_vec;
  assign oValid       = valid_q;
  assign oPacket      = data_q;
  assign oSop         = sop_q;
  assign oEop         = eop_q;
  assign oByte_enable = be_q;
  assign oSrc_id      = src_id_q;
  assign oPkt_count   = pkt_cnt_q;
  assign oDrop_count  = drop_cnt_q;

endmodule

// File: tb/tb_packet_source_arbiter.sv
// Directed stimulus for packet_source_arbiter with a queue-based scoreboard on the output port.
module tb_packet_source_arbiter;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int CW = 16;

  logic           clk;
  logic           rst;
  logic [NS-1:0]  iValid;
  logic [NS*DW-1:0] iPacket;
  logic [NS-1:0]  iSop;
  logic [NS-1:0]  iEop;
  logic [NS*BW-1:0] iByte_enable;
  logic [NS-1:0]  oReady;
  logic           iReady;
  logic           oValid;
  logic [DW-1:0]  oPacket;
  logic           oSop;
  logic           oEop;
  logic [BW-1:0]  oByte_enable;
  logic [1:0]     oSrc_id;
  logic [CW-1:0]  oPkt_count;
  logic [CW-1:0]  oDrop_count;

  packet_source_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .BE_W(BW), .CNT_W(CW)) dut (
    .iClk(clk), .iReset(rst), .iValid(iValid), .iPacket(iPacket), .iSop(iSop), .iEop(iEop),
    .iByte_enable(iByte_enable), .oReady(oReady), .iReady(iReady), .oValid(oValid),
    .oPacket(oPacket), .oSop(oSop), .oEop(oEop), .oByte_enable(oByte_enable),
    .oSrc_id(oSrc_id), .oPkt_count(oPkt_count), .oDrop_count(oDrop_count)
  );

  typedef struct {
    logic [1:0]    src;
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
    logic [BW-1:0] be;
  } beat_t;

  beat_t src_q[NS][$];
  beat_t exp_q[$];
  int    out_cyc[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_pop = 0;
  int    cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic src_pkt(input int s, input int n, input logic [DW-1:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.src = 2'(s); b.dat = base + DW'(i); b.sop = (i == 0); b.eop = (i == n - 1); b.be = 8'hFF;
      src_q[s].push_back(b);
    end
  endtask

  task automatic exp_pkt(input int s, input int n, input logic [DW-1:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.src = 2'(s); b.dat = base + DW'(i); b.sop = (i == 0); b.eop = (i == n - 1); b.be = 8'hFF;
      exp_q.push_back(b);
    end
  endtask

  function automatic int pending();
    int p = exp_q.size();
    for (int s = 0; s < NS; s++) p += src_q[s].size();
    return p;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    while (pending() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (pending() != 0) chk({name, "_timeout"}, 128'(pending()), 128'd0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_pops(input int target, input int budget);
    int t = 0;
    while (n_pop < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (n_pop < target) chk("pop_timeout", 128'(n_pop), 128'(target));
  endtask

  // Source driver: present each queue's head beat, retire it once the handshake completes.
  initial begin
    logic [NS-1:0] xfer;
    iValid = '0; iSop = '0; iEop = '0; iPacket = '0; iByte_enable = '0;
    forever begin
      @(negedge clk);
      xfer = iValid & oReady;
      @(posedge clk);
      #1;
      iValid = '0; iSop = '0; iEop = '0; iPacket = '0; iByte_enable = '0;
      for (int s = 0; s < NS; s++) begin
        if (xfer[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
        if (src_q[s].size() > 0) begin
          iValid[s] = 1'b1;
          iSop[s] = src_q[s][0].sop;
          iEop[s] = src_q[s][0].eop;
          iPacket[s*DW +: DW] = src_q[s][0].dat;
          iByte_enable[s*BW +: BW] = src_q[s][0].be;
        end
      end
    end
  end

  // Monitor: every output transfer must match the head of the expected queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && oValid && iReady) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {oSrc_id, oPacket}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {oSrc_id, oPacket, oSop, oEop, oByte_enable}, {e.src, e.dat, e.sop, e.eop, e.be});
        end
        n_pop++;
        out_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    beat_t b;
    int base;
    rst = 1'b1;
    iReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_asserted_out", {oValid, oReady, oSop, oEop, oSrc_id, oPkt_count, oDrop_count}, 128'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {oValid, oReady, oSop, oEop, oByte_enable, oSrc_id}, 128'd0);
    chk("reset_counts", {oPkt_count, oDrop_count}, 128'd0);

    // All four sources request single-beat packets back to back.
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < NS; s++) begin
        src_pkt(s, 1, 64'h2000 + 64'(s * 16 + k));
        exp_pkt(s, 1, 64'h2000 + 64'(s * 16 + k));
      end
    wait_idle("rr", 200);
    chk("rr_pkt_count", 128'(oPkt_count), 128'd8);

    // Sources 0 and 2 collide: 0 goes first, one idle cycle before 2.
    out_cyc.delete();
    src_pkt(0, 3, 64'h1000_0000);
    src_pkt(2, 3, 64'h1200_0000);
    exp_pkt(0, 3, 64'h1000_0000);
    exp_pkt(2, 3, 64'h1200_0000);
    wait_idle("collide", 200);
    chk("collide_beats", 128'(out_cyc.size()), 128'd6);
    if (out_cyc.size() == 6) begin
      chk("collide_back_to_back", 128'(out_cyc[1] - out_cyc[0]), 128'd1);
      chk("collide_gap", 128'(out_cyc[3] - out_cyc[2]), 128'd2);
    end
    chk("collide_pkt_count", 128'(oPkt_count), 128'd10);

    // Downstream stall for 5 cycles while beat 2 of a 4-beat packet is held.
    src_pkt(1, 4, 64'h3000);
    exp_pkt(1, 4, 64'h3000);
    begin
      int t = 0;
      do begin
        @(posedge clk);
        #1;
        t++;
      end while (!(oValid && oPacket == 64'h3001) && t < 100);
      chk("stall_found_beat2", 128'(oPacket), 128'h3001);
    end
    iReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {oValid, oPacket, oByte_enable, oReady[1]}, {1'b1, 64'h3001, 8'hFF, 1'b0});
    end
    @(posedge clk);
    #1 iReady = 1'b1;
    wait_idle("stall", 200);
    chk("stall_pkt_count", 128'(oPkt_count), 128'd11);

    // Non-SOP beats while idle are discarded and counted.
    for (int i = 0; i < 2; i++) begin
      b.src = 2'd1; b.dat = 64'hDEAD + 64'(i); b.sop = 1'b0; b.eop = 1'b0; b.be = 8'hFF;
      src_q[1].push_back(b);
    end
    wait_idle("drop", 50);
    chk("drop_count", 128'(oDrop_count), 128'd2);
    chk("drop_pkt_count", 128'(oPkt_count), 128'd11);

    // Partial byte enables on the last beat.
    for (int i = 0; i < 3; i++) begin
      b.src = 2'd2; b.dat = 64'h5000 + 64'(i); b.sop = (i == 0); b.eop = (i == 2);
      b.be = (i == 2) ? 8'h0F : 8'hFF;
      src_q[2].push_back(b);
      exp_q.push_back(b);
    end
    wait_idle("be", 200);
    chk("be_pkt_count", 128'(oPkt_count), 128'd12);

    // Reset in the middle of a 5-beat packet; pointer is 3 beforehand.
    base = n_pop;
    src_pkt(0, 5, 64'h6000);
    exp_pkt(0, 5, 64'h6000);
    wait_pops(base + 2, 200);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    for (int s = 0; s < NS; s++) src_q[s].delete();
    #1;
    chk("midrst_outputs", {oValid, oReady, oSop, oEop, oPacket, oByte_enable, oSrc_id}, 128'd0);
    chk("midrst_counts", {oPkt_count, oDrop_count}, 128'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {oValid, oReady, oPkt_count, oDrop_count}, 128'd0);

    // Sources 1 and 3 together: pointer restarted at 0 so 1 precedes 3.
    src_pkt(3, 1, 64'h7300);
    src_pkt(1, 1, 64'h7100);
    exp_pkt(1, 1, 64'h7100);
    exp_pkt(3, 1, 64'h7300);
    wait_idle("post_rst", 200);
    chk("post_rst_pkt_count", 128'(oPkt_count), 128'd2);
    chk("post_rst_last_src", 128'(oSrc_id), 128'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
